// File: rtl/tt_wb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_wb_bridge_pkg
// Description : Shared command/subop encodings, status layout and pad constant
//               for the pin-multiplexed Wishbone master bridge.
// Revision    : 2.0
// ============================================================================
package tt_wb_bridge_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE   = 3'd0,
        CMD_EXEC   = 3'd1,
        CMD_ADR_LD = 3'd2,
        CMD_DO_LD  = 3'd3,
        CMD_DI_RD  = 3'd4,
        CMD_STATUS = 3'd5,
        CMD_RSV6   = 3'd6,
        CMD_RSV7   = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        SUB_NOP     = 3'd0,
        SUB_RESET   = 3'd1,
        SUB_WBSEL   = 3'd2,
        SUB_MODE    = 3'd3,
        SUB_DISABLE = 3'd4,
        SUB_ENABLE  = 3'd5,
        SUB_READ    = 3'd6,
        SUB_WRITE   = 3'd7
    } subop_e;

    localparam int c_st_busy    = 7;
    localparam int c_st_done    = 6;
    localparam int c_st_err     = 5;
    localparam int c_st_tout    = 4;
    localparam int c_st_autoinc = 3;
    localparam int c_st_cyc     = 2;

    localparam logic [7:0] c_uio_oe = 8'b0001_0000;

    function automatic logic [7:0] status_byte(
        input logic busy,
        input logic done,
        input logic err,
        input logic tout,
        input logic autoinc,
        input logic cyc
    );
        logic [7:0] sb;
        sb               = '0;
        sb[c_st_busy]    = busy;
        sb[c_st_done]    = done;
        sb[c_st_err]     = err;
        sb[c_st_tout]    = tout;
        sb[c_st_autoinc] = autoinc;
        sb[c_st_cyc]     = cyc;
        return sb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_wb_byte_seq.sv
`default_nettype none
// ============================================================================
// Module      : tt_wb_byte_seq
// Description : Byte index sequencer with command-run detection and per-command
//               wrap length; shared by the address, data-out and data-in paths.
// Revision    : 2.0
// ============================================================================
module tt_wb_byte_seq
    import tt_wb_bridge_pkg::*;
#(
    parameter int NB_ADR = 2,
    parameter int NB_DAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_clr,
    input  cmd_e       cmd,
    output logic [1:0] idx,
    output logic       first
);

    localparam logic [1:0] c_last_adr = 2'(NB_ADR - 1);
    localparam logic [1:0] c_last_dat = 2'(NB_DAT - 1);

    cmd_e       cmd_last_q, cmd_last_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] w_last;

    // idx is the byte used in the current cycle; idx_q remembers the previous one
    always_comb begin
        first  = (cmd != cmd_last_q);
        w_last = (cmd == CMD_ADR_LD) ? c_last_adr : c_last_dat;
        if (first || (idx_q == w_last)) begin
            idx = 2'd0;
        end else begin
            idx = idx_q + 2'd1;
        end
        cmd_last_d = soft_clr ? CMD_IDLE : cmd;
        idx_d      = soft_clr ? 2'd0 : idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_last_q <= CMD_IDLE;
            idx_q      <= 2'd0;
        end else begin
            cmd_last_q <= cmd_last_d;
            idx_q      <= idx_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tt_wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tt_wb_master_bridge
// Description : Pin-multiplexed Wishbone classic master for TinyTapeout with
//               ERR handling, bus timeout, address auto-increment and status.
// Revision    : 2.0
// ============================================================================
module tt_wb_master_bridge
    import tt_wb_bridge_pkg::*;
#(
    parameter int ADR_W   = 14,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [7:0]           ui_in,
    output logic [7:0]           uo_out,
    input  logic [7:0]           uio_in,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic                 wb_CYC,
    output logic                 wb_STB,
    output logic                 wb_WE,
    input  logic                 wb_ACK,
    input  logic                 wb_ERR,
    output logic [ADR_W-1:0]     wb_ADR,
    output logic [DAT_W-1:0]     wb_DAT_MOSI,
    input  logic [DAT_W-1:0]     wb_DAT_MISO,
    output logic [DAT_W/8-1:0]   wb_SEL
);

    localparam int c_nbd = DAT_W / 8;
    localparam int c_nba = (ADR_W + 7) / 8;
    localparam int c_tw  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_tlast = c_tw'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] do_q, do_d;
    logic [DAT_W-1:0] di_q, di_d;
    logic [c_nbd-1:0] sel_q, sel_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tout_q, tout_d;
    logic             autoinc_q, autoinc_d;
    logic [c_tw-1:0]  tcnt_q, tcnt_d;
    logic [7:0]       uo_q, uo_d;

    cmd_e        w_cmd;
    subop_e      w_sub;
    logic [1:0]  w_idx;
    logic        w_first;
    logic        w_exec1;
    logic        w_soft_clr;
    logic [4:0]  w_bit;
    logic [31:0] w_adr_pad;
    logic [31:0] w_do_pad;
    logic [31:0] w_di_pad;

    assign w_cmd      = cmd_e'(uio_in[7:5]);
    assign w_sub      = subop_e'(ui_in[2:0]);
    assign w_exec1    = (w_cmd == CMD_EXEC) && w_first;
    assign w_soft_clr = w_exec1 && (w_sub == SUB_RESET);
    assign w_bit      = {w_idx, 3'b000};

    wire w_unused = &{1'b0, ena, uio_in[4:0]};

    tt_wb_byte_seq #(
        .NB_ADR (c_nba),
        .NB_DAT (c_nbd)
    ) u_byte_seq (
        .clk      (clk),
        .rst      (rst),
        .soft_clr (w_soft_clr),
        .cmd      (w_cmd),
        .idx      (w_idx),
        .first    (w_first)
    );

    always_comb begin
        adr_d     = adr_q;
        do_d      = do_q;
        di_d      = di_q;
        sel_d     = sel_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        done_d    = done_q;
        err_d     = err_q;
        tout_d    = tout_q;
        autoinc_d = autoinc_q;
        tcnt_d    = tcnt_q;
        uo_d      = di_q[7:0];

        // Byte-wide views padded to 32 bits so one index works for any width
        w_adr_pad             = 32'(adr_q);
        w_adr_pad[w_bit +: 8] = ui_in;
        w_do_pad              = 32'(do_q);
        w_do_pad[w_bit +: 8]  = ui_in;
        w_di_pad              = 32'(di_q);

        if (stb_q) begin
            if (wb_ERR) begin
                stb_d  = 1'b0;
                we_d   = 1'b0;
                err_d  = 1'b1;
                done_d = 1'b1;
            end else if (wb_ACK) begin
                stb_d  = 1'b0;
                we_d   = 1'b0;
                done_d = 1'b1;
                if (!we_q) begin
                    di_d = wb_DAT_MISO;
                end
                if (autoinc_q) begin
                    adr_d = adr_q + ADR_W'(1);
                end
            end else if ((TIMEOUT != 0) && (tcnt_q == c_tlast)) begin
                stb_d  = 1'b0;
                tout_d = 1'b1;
                done_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + c_tw'(1);
            end
        end

        case (w_cmd)
            CMD_ADR_LD: if (!stb_q) adr_d = w_adr_pad[ADR_W-1:0];
            CMD_DO_LD:  if (!stb_q) do_d  = w_do_pad[DAT_W-1:0];
            CMD_DI_RD:  uo_d = w_di_pad[w_bit +: 8];
            CMD_STATUS: uo_d = status_byte(stb_q, done_q, err_q, tout_q, autoinc_q, cyc_q);
            default:    uo_d = di_q[7:0];
        endcase

        if (w_exec1) begin
            case (w_sub)
                SUB_WBSEL: sel_d     = ui_in[4 +: c_nbd];
                SUB_MODE:  autoinc_d = ui_in[4];
                SUB_DISABLE: begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (stb_q) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
                SUB_ENABLE: cyc_d = 1'b1;
                SUB_READ, SUB_WRITE: begin
                    if (!stb_q) begin
                        if (cyc_q) begin
                            we_d   = ui_in[0];
                            stb_d  = 1'b1;
                            done_d = 1'b0;
                            err_d  = 1'b0;
                            tout_d = 1'b0;
                            tcnt_d = '0;
                        end else begin
                            err_d  = 1'b1;
                            done_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (w_soft_clr) begin
            adr_d     = '0;
            do_d      = '0;
            di_d      = '0;
            sel_d     = '1;
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            we_d      = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            tout_d    = 1'b0;
            autoinc_d = 1'b0;
            tcnt_d    = '0;
            uo_d      = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q     <= '0;
            do_q      <= '0;
            di_q      <= '0;
            sel_q     <= '1;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tout_q    <= 1'b0;
            autoinc_q <= 1'b0;
            tcnt_q    <= '0;
            uo_q      <= 8'h00;
        end else begin
            adr_q     <= adr_d;
            do_q      <= do_d;
            di_q      <= di_d;
            sel_q     <= sel_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tout_q    <= tout_d;
            autoinc_q <= autoinc_d;
            tcnt_q    <= tcnt_d;
            uo_q      <= uo_d;
        end
    end

    assign wb_CYC      = cyc_q;
    assign wb_STB      = stb_q;
    assign wb_WE       = we_q;
    assign wb_ADR      = adr_q;
    assign wb_DAT_MOSI = do_q;
    assign wb_SEL      = stb_q ? (we_q ? sel_q : {c_nbd{1'b1}}) : {c_nbd{1'b0}};
    assign uo_out      = uo_q;
    assign uio_out     = {3'b000, done_q, 4'b0000};
    assign uio_oe      = c_uio_oe;

endmodule
`default_nettype wire

// File: tb/tb_tt_wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_wb_master_bridge
// Description : Scoreboard bench for the Wishbone master bridge with a
//               behavioural model, scripted slave and randomized transactions.
// Revision    : 2.0
// ============================================================================
module tb_tt_wb_master_bridge;

    localparam int ADR_W   = 14;
    localparam int DAT_W   = 32;
    localparam int TIMEOUT = 255;

    localparam logic [2:0] C_IDLE = 3'd0, C_EXEC = 3'd1, C_ADR = 3'd2;
    localparam logic [2:0] C_DO = 3'd3, C_DIRD = 3'd4, C_STAT = 3'd5;
    localparam logic [2:0] S_RESET = 3'd1, S_WBSEL = 3'd2, S_MODE = 3'd3;
    localparam logic [2:0] S_DISABLE = 3'd4, S_ENABLE = 3'd5, S_READ = 3'd6, S_WRITE = 3'd7;
    localparam int M_ACK = 0, M_ERR = 1, M_NONE = 2, M_BOTH = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b1;
    logic [7:0]       ui_in = 8'h00;
    logic [7:0]       uo_out;
    logic [7:0]       uio_in = 8'h00;
    logic [7:0]       uio_out;
    logic [7:0]       uio_oe;
    logic             wb_CYC, wb_STB, wb_WE;
    logic             wb_ACK = 1'b0;
    logic             wb_ERR = 1'b0;
    logic [ADR_W-1:0] wb_ADR;
    logic [DAT_W-1:0] wb_DAT_MOSI;
    logic [DAT_W-1:0] wb_DAT_MISO = '0;
    logic [3:0]       wb_SEL;

    tt_wb_master_bridge #(
        .ADR_W   (ADR_W),
        .DAT_W   (DAT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .ui_in       (ui_in),
        .uo_out      (uo_out),
        .uio_in      (uio_in),
        .uio_out     (uio_out),
        .uio_oe      (uio_oe),
        .wb_CYC      (wb_CYC),
        .wb_STB      (wb_STB),
        .wb_WE       (wb_WE),
        .wb_ACK      (wb_ACK),
        .wb_ERR      (wb_ERR),
        .wb_ADR      (wb_ADR),
        .wb_DAT_MOSI (wb_DAT_MOSI),
        .wb_DAT_MISO (wb_DAT_MISO),
        .wb_SEL      (wb_SEL)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } req_t;

    req_t       reqq[$];
    logic [7:0] rdq[$];
    int         n_checks = 0;
    int         n_err    = 0;
    int         n_rises  = 0;
    logic       stb_prev = 1'b0;

    // Behavioural model of the bridge's architectural state
    logic [13:0] m_adr;
    logic [31:0] m_do, m_di;
    logic [3:0]  m_sel;
    logic        m_cyc, m_done, m_err, m_tout, m_auto;

    int          slv_mode = M_ACK;
    int          slv_dly  = 0;
    logic [31:0] slv_data = '0;
    int          scnt     = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_adr = '0; m_do = '0; m_di = '0; m_sel = 4'hF;
        m_cyc = 0; m_done = 0; m_err = 0; m_tout = 0; m_auto = 0;
    endfunction

    function automatic logic [7:0] m_status();
        return {1'b0, m_done, m_err, m_tout, m_auto, m_cyc, 2'b00};
    endfunction

    // Slave: terminates slv_dly cycles into the strobe according to slv_mode
    always @(negedge clk) begin
        if (rst || !wb_STB) begin
            wb_ACK = 1'b0;
            wb_ERR = 1'b0;
            scnt   = 0;
        end else begin
            scnt++;
            wb_ACK = ((scnt - 1) == slv_dly) && (slv_mode == M_ACK || slv_mode == M_ERR ? slv_mode == M_ACK : slv_mode == M_BOTH);
            wb_ERR = ((scnt - 1) == slv_dly) && (slv_mode == M_ERR || slv_mode == M_BOTH);
        end
        wb_DAT_MISO = slv_data;
    end

    // Monitor: read-back bytes and bus requests are popped from the scoreboard
    always @(posedge clk) begin
        logic [2:0] c;
        logic       rs;
        req_t       r;
        c  = uio_in[7:5];
        rs = rst;
        #1;
        if (!rs && !rst) begin
            if (c == C_DIRD || c == C_STAT) begin
                if (rdq.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL uo_unexpected: got 0x%0h, expected no read-back", uo_out);
                end else begin
                    chk("uo_out", {24'h0, uo_out}, {24'h0, rdq.pop_front()});
                end
            end
            if (wb_STB && !stb_prev) begin
                n_rises++;
                if (reqq.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL stb_unexpected: got STB at adr 0x%0h, expected none", wb_ADR);
                end else begin
                    r = reqq.pop_front();
                    chk("req_adr", 32'(wb_ADR), 32'(r.adr));
                    chk("req_we", 32'(wb_WE), 32'(r.we));
                    chk("req_sel", 32'(wb_SEL), 32'(r.sel));
                    if (r.we) chk("req_dat", wb_DAT_MOSI, r.dat);
                end
            end
        end
        stb_prev = wb_STB;
    end

    task automatic drive(input logic [2:0] c, input logic [7:0] v);
        @(negedge clk);
        uio_in = {c, 5'($urandom)};
        ui_in  = v;
    endtask

    task automatic exec(input logic [2:0] sub, input logic [3:0] hi);
        drive(C_EXEC, {hi, 1'($urandom), sub});
        drive(C_IDLE, 8'($urandom));
    endtask

    task automatic load_adr(input logic [15:0] v);
        drive(C_ADR, v[7:0]);
        drive(C_ADR, v[15:8]);
        drive(C_IDLE, 8'($urandom));
        m_adr = v[13:0];
    endtask

    task automatic load_do(input logic [31:0] v);
        for (int i = 0; i < 4; i++) drive(C_DO, v[8*i +: 8]);
        drive(C_IDLE, 8'($urandom));
        m_do = v;
    endtask

    task automatic status_rd();
        rdq.push_back(m_status());
        drive(C_STAT, 8'($urandom));
        drive(C_IDLE, 8'($urandom));
    endtask

    task automatic di_read(input int n);
        for (int i = 0; i < n; i++) begin
            rdq.push_back(8'(m_di >> (8 * (i % 4))));
            drive(C_DIRD, 8'($urandom));
        end
        drive(C_IDLE, 8'($urandom));
    endtask

    task automatic bus(input logic wr);
        req_t r;
        int   cnt;
        int   exp_cnt;
        if (m_cyc) begin
            r.adr = m_adr; r.we = wr; r.sel = wr ? m_sel : 4'hF; r.dat = m_do;
            reqq.push_back(r);
        end
        drive(C_EXEC, {4'($urandom), 1'($urandom), wr ? S_WRITE : S_READ});
        drive(C_IDLE, 8'($urandom));
        cnt = 0;
        while (wb_STB && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        if (!m_cyc) begin
            m_err = 1; m_done = 1; exp_cnt = 0;
        end else begin
            m_done = 1; m_err = 0; m_tout = 0;
            exp_cnt = slv_dly + 1;
            case (slv_mode)
                M_ACK: begin
                    if (!wr) m_di = slv_data;
                    if (m_auto) m_adr = m_adr + 14'd1;
                end
                M_NONE: begin
                    m_tout = 1; exp_cnt = TIMEOUT;
                end
                default: m_err = 1;
            endcase
        end
        chk("stb_cycles", cnt, exp_cnt);
        chk("done_pin", 32'(uio_out), {24'h0, 3'b000, m_done, 4'b0000});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   r0;
        int   rr;
        req_t q;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_uo", 32'(uo_out), 0);
        chk("rst_uio_out", 32'(uio_out), 0);
        chk("rst_uio_oe", 32'(uio_oe), 32'h10);
        chk("rst_ctl", {29'h0, wb_CYC, wb_STB, wb_WE}, 0);
        chk("rst_sel", 32'(wb_SEL), 0);
        chk("rst_adr", 32'(wb_ADR), 0);
        rst = 1'b0;

        load_adr(16'h1234);
        load_do(32'hDEADBEEF);
        exec(S_ENABLE, 4'h0); m_cyc = 1;
        slv_mode = M_ACK; slv_dly = 3;
        bus(1'b1);
        status_rd();

        slv_data = 32'hCAFEF00D; slv_dly = 1;
        bus(1'b0);
        di_read(5);

        exec(S_MODE, 4'h1); m_auto = 1;
        load_adr(16'h3FFF);
        repeat (3) begin
            slv_data = $urandom;
            bus(1'b0);
        end
        chk("autoinc_adr", 32'(wb_ADR), 32'(m_adr));
        exec(S_MODE, 4'h0); m_auto = 0;

        slv_mode = M_NONE;
        bus(1'b0);
        status_rd();

        slv_mode = M_BOTH; slv_dly = 2; slv_data = 32'h11223344;
        bus(1'b0);
        di_read(4);
        status_rd();

        exec(S_WBSEL, 4'h5); m_sel = 4'h5;
        slv_mode = M_ACK; slv_dly = 0;
        load_do(32'h0BADF00D);
        bus(1'b1);

        exec(S_DISABLE, 4'h0); m_cyc = 0;
        bus(1'b0);
        status_rd();

        exec(S_ENABLE, 4'h0); m_cyc = 1;
        slv_mode = M_ACK; slv_dly = 0; slv_data = $urandom;
        q.adr = m_adr; q.we = 0; q.sel = 4'hF; q.dat = m_do;
        reqq.push_back(q);
        r0 = n_rises;
        repeat (10) drive(C_EXEC, {4'($urandom), 1'b0, S_READ});
        drive(C_IDLE, 8'h00);
        drive(C_IDLE, 8'h00);
        chk("single_stb", n_rises - r0, 1);
        m_di = slv_data; m_done = 1; m_err = 0; m_tout = 0;
        di_read(4);

        slv_mode = M_NONE;
        reqq.push_back(q);
        drive(C_EXEC, {4'h0, 1'b0, S_READ});
        repeat (4) drive(C_IDLE, 8'h00);
        exec(S_DISABLE, 4'h0);
        chk("abort_stb", {30'h0, wb_CYC, wb_STB}, 0);
        m_cyc = 0; m_err = 1; m_done = 1; m_tout = 0;
        status_rd();

        exec(S_ENABLE, 4'h0); m_cyc = 1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                m_auto = 1'($urandom);
                exec(S_MODE, {3'($urandom), m_auto});
            end
            if ($urandom_range(0, 3) == 0) begin
                m_sel = 4'($urandom);
                exec(S_WBSEL, m_sel);
            end
            load_adr(16'($urandom));
            load_do($urandom);
            rr = $urandom_range(0, 9);
            slv_mode = (rr < 7) ? M_ACK : (rr < 9) ? M_ERR : M_BOTH;
            slv_dly  = $urandom_range(0, 4);
            slv_data = $urandom;
            bus(1'($urandom));
            status_rd();
            di_read($urandom_range(1, 6));
        end

        exec(S_MODE, 4'h1); m_auto = 1;
        load_adr(16'h2A5C);
        exec(S_RESET, 4'h0);
        model_reset();
        chk("soft_rst_adr", 32'(wb_ADR), 0);
        chk("soft_rst_cyc", 32'(wb_CYC), 0);
        status_rd();
        di_read(2);

        exec(S_ENABLE, 4'h0); m_cyc = 1;
        slv_mode = M_NONE;
        q.adr = m_adr; q.we = 0; q.sel = 4'hF; q.dat = m_do;
        reqq.push_back(q);
        drive(C_EXEC, {4'h0, 1'b0, S_READ});
        drive(C_IDLE, 8'h00);
        drive(C_IDLE, 8'h00);
        chk("pre_rst_stb", 32'(wb_STB), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ctl", {29'h0, wb_CYC, wb_STB, wb_WE}, 0);
        chk("mid_rst_uo", 32'(uo_out), 0);
        chk("mid_rst_uio", 32'(uio_out), 0);
        chk("mid_rst_sel", 32'(wb_SEL), 0);
        chk("mid_rst_oe", 32'(uio_oe), 32'h10);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        status_rd();

        repeat (3) drive(C_IDLE, 8'h00);
        chk("rdq_drained", rdq.size(), 0);
        chk("reqq_drained", reqq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
